instr_sequencer: RTL and testbench

// - Feeds the datapath instruction stream. Fetches N instructions from instruction memory into a prefetch FIFO.
// - Issues one instruction per enabled cycle to the instruction decoder and owns the global pipe_en (stall) signal.
// - After the last issue, drains the datapath pipeline, then reports done.
// - Sits between the instruction memory and the decoder that drives the datapath control inputs.

---
 rtl/instr_decd_pkg.sv | 9 +
 rtl/seq_prefetch_fifo.sv | 54 +++++
 rtl/instr_sequencer.sv | 143 ++++++++++++++
 tb/tb_instr_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decd_pkg.sv
// Shared types and constants for the instruction sequencer and decoder.
package instr_decd_pkg;

   localparam int unsigned INSTR_L = 64;
   localparam logic [INSTR_L-1:0] NOP = '0;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

endpackage

// File: rtl/seq_prefetch_fifo.sv
// Synchronous prefetch FIFO; head is registered storage, no write-through bypass.
module seq_prefetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_wdata,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_empty,
   output logic                   o_full,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   // A push into a full FIFO is only accepted when the head leaves in the same cycle.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Fetches a program into a prefetch FIFO, issues one instruction per enabled
// cycle, drains the datapath pipeline and pulses done.
module instr_sequencer
   import instr_decd_pkg::*;
#(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PIPE_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [ADDR_W-1:0]  i_base_addr,
   input  logic [ADDR_W-1:0]  i_n_instr,
   output logic               o_instr_req,
   output logic [ADDR_W-1:0]  o_instr_addr,
   input  logic               i_instr_gnt,
   input  logic               i_instr_rvld,
   input  logic [INSTR_L-1:0] i_instr_rdata,
   input  logic               i_ext_stall,
   output logic               o_pipe_en,
   output logic               o_instr_vld,
   output logic [INSTR_L-1:0] o_instr_out,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

   seq_state_t        r_state;
   seq_state_t        w_state_d;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_n;
   logic [ADDR_W-1:0] r_fetched;
   logic [ADDR_W-1:0] r_issued;
   logic [CW-1:0]     r_outst;
   logic [DW-1:0]     r_drain;
   logic              r_err;

   logic               w_start_acc;
   logic               w_gnt_acc;
   logic               w_push;
   logic               w_pop;
   logic               w_straggler;
   logic               w_credit_ok;
   logic               w_fifo_empty;
   logic               w_fifo_full;
   logic [CW-1:0]      w_fifo_count;
   logic [INSTR_L-1:0] w_head;

   seq_prefetch_fifo #(
      .WIDTH (INSTR_L),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (i_instr_rdata),
      .o_rdata (w_head),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full),
      .o_count (w_fifo_count)
   );

   // Every fetch in flight owns a FIFO slot, so responses can never overflow it.
   assign w_credit_ok = !w_fifo_full &&
                        (({1'b0, r_outst} + {1'b0, w_fifo_count}) < (CW+1)'(FIFO_DEPTH));
   assign o_instr_req  = (r_state == RUN) && (r_fetched < r_n) && w_credit_ok;
   assign o_instr_addr = r_addr;
   assign w_start_acc  = (r_state == IDLE) && i_start;
   assign w_gnt_acc    = o_instr_req && i_instr_gnt;
   assign w_straggler  = i_instr_rvld && (r_outst == '0);
   assign w_push       = i_instr_rvld && !w_straggler;
   assign o_busy       = (r_state != IDLE);
   assign o_done       = (r_state == DONE);
   assign o_err        = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_d;
   end

   always_comb begin
      w_state_d   = r_state;
      w_pop       = 1'b0;
      o_pipe_en   = 1'b0;
      o_instr_vld = 1'b0;
      o_instr_out = NOP;
      unique case (r_state)
         IDLE: begin
            if (i_start) w_state_d = (i_n_instr == '0) ? DONE : RUN;
         end
         RUN: begin
            if (!w_fifo_empty && !i_ext_stall) begin
               w_pop       = 1'b1;
               o_pipe_en   = 1'b1;
               o_instr_vld = 1'b1;
               o_instr_out = w_head;
               if (r_issued + ADDR_W'(1) == r_n) w_state_d = DRAIN;
            end
         end
         DRAIN: begin
            o_pipe_en = !i_ext_stall;
            if (!i_ext_stall && (r_drain == DW'(PIPE_DEPTH - 1))) w_state_d = DONE;
         end
         DONE:    w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr    <= '0;
         r_n       <= '0;
         r_fetched <= '0;
         r_issued  <= '0;
         r_drain   <= '0;
         r_outst   <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_addr    <= i_base_addr;
            r_n       <= i_n_instr;
            r_fetched <= '0;
            r_issued  <= '0;
            r_drain   <= '0;
         end else begin
            if (w_gnt_acc) begin
               r_addr    <= r_addr + ADDR_W'(1);
               r_fetched <= r_fetched + ADDR_W'(1);
            end
            if (w_pop) r_issued <= r_issued + ADDR_W'(1);
            if ((r_state == DRAIN) && o_pipe_en) r_drain <= r_drain + DW'(1);
         end
         if (w_gnt_acc && !w_push)      r_outst <= r_outst + CW'(1);
         else if (!w_gnt_acc && w_push) r_outst <= r_outst - CW'(1);
         r_err <= w_start_acc ? 1'b0 : (r_err | w_straggler);
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: a memory responder feeds the DUT, expected instructions are
// queued at launch and checked by a monitor whenever the DUT issues.
module tb_instr_sequencer;
   localparam int FIFO_DEPTH = 4;
   localparam int PIPE_DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic [15:0] i_base_addr = '0;
   logic [15:0] i_n_instr = '0;
   logic        o_instr_req;
   logic [15:0] o_instr_addr;
   logic        i_instr_gnt = 1'b0;
   logic        i_instr_rvld = 1'b0;
   logic [63:0] i_instr_rdata = '0;
   logic        i_ext_stall = 1'b0;
   logic        o_pipe_en, o_instr_vld, o_busy, o_done, o_err;
   logic [63:0] o_instr_out;

   instr_sequencer #(
      .ADDR_W     (16),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PIPE_DEPTH (PIPE_DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_start       (i_start),
      .i_base_addr   (i_base_addr),
      .i_n_instr     (i_n_instr),
      .o_instr_req   (o_instr_req),
      .o_instr_addr  (o_instr_addr),
      .i_instr_gnt   (i_instr_gnt),
      .i_instr_rvld  (i_instr_rvld),
      .i_instr_rdata (i_instr_rdata),
      .i_ext_stall   (i_ext_stall),
      .o_pipe_en     (o_pipe_en),
      .o_instr_vld   (o_instr_vld),
      .o_instr_out   (o_instr_out),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_err         (o_err)
   );

   always #5 clk = ~clk;

   typedef struct {int due; logic [15:0] addr;} rsp_t;

   int n_chk = 0, n_pass = 0, cyc = 0;
   logic [63:0] exp_data_q[$];
   logic [15:0] exp_addr_q[$];
   rsp_t        pend_q[$];
   // stimulus knobs
   int lat_base = 1, gnt_hold = 0, stall_left = 0, last_due = 0;
   bit gnt_rand = 0, lat_rand = 0, stall_rand = 0, sched_stall = 0, s1 = 0, s2 = 0;
   // run observations
   int n_cur = 0, start_cyc = 0, first_req = -1, first_vld = -1, done_cyc = 0;
   int pe_cnt = 0, iss_run = 0, iss_tot = 0, gnt_tot = 0, done_cnt = 0;
   int since_vld = 0, stall_since = 0, drain_len = 0, drain_stall = 0;
   int max_if = 0, credit_viol = 0, nop_viol = 0, stall_viol = 0;
   bit req_seen = 0, prev_wait = 0;
   logic [15:0] prev_addr = '0;

   function automatic logic [63:0] mem_f(input logic [15:0] a);
      logic [31:0] h;
      h = 32'(a) * 32'h9E3779B1;
      return {16'hA5C3 ^ a, a, h};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory responder: grants, in-order responses, and ext_stall generation.
   initial forever begin
      int inflight, due;
      @(posedge clk);
      #1;
      i_instr_gnt  = 1'b0;
      i_instr_rvld = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         i_instr_rvld  = 1'b1;
         i_instr_rdata = mem_f(pend_q[0].addr);
         void'(pend_q.pop_front());
      end
      if (!rst) begin
         inflight = gnt_tot - iss_tot;
         if (inflight > max_if) max_if = inflight;
         if (o_instr_req && inflight >= FIFO_DEPTH) credit_viol++;
         if (o_instr_req && first_req < 0) first_req = cyc;
         if (prev_wait) begin
            chk("addr_held", o_instr_addr, prev_addr);
            chk("req_held", o_instr_req, 1);
         end
         if (o_instr_req) begin
            if (gnt_hold > 0) gnt_hold--;
            else i_instr_gnt = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
         end
         prev_wait = o_instr_req && !i_instr_gnt;
         prev_addr = o_instr_addr;
         if (o_instr_req && i_instr_gnt) begin
            gnt_tot++;
            if (exp_addr_q.size() == 0) begin
               n_chk++;
               $display("FAIL fetch_extra: got addr 0x%0h, expected no fetch", o_instr_addr);
            end else chk("fetch_addr", o_instr_addr, exp_addr_q.pop_front());
            due = cyc + lat_base + (lat_rand ? int'($urandom_range(0, 2)) : 0);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_q.push_back('{due: due, addr: o_instr_addr});
         end
         if (sched_stall && !s1 && iss_run == 1) begin stall_left = 3; s1 = 1; end
         if (sched_stall && !s2 && n_cur > 0 && iss_run == n_cur) begin stall_left = 2; s2 = 1; end
      end
      i_ext_stall = (stall_left > 0) || (stall_rand && $urandom_range(0, 3) == 0);
      if (stall_left > 0) stall_left--;
   end

   // Monitor: pops the scoreboard on every issued instruction.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (o_pipe_en) pe_cnt++;
         if (o_instr_req) req_seen = 1;
         if (i_ext_stall && (o_pipe_en || o_instr_vld)) stall_viol++;
         if (o_instr_vld) begin
            if (!o_pipe_en) nop_viol++;
            if (exp_data_q.size() == 0) begin
               n_chk++;
               $display("FAIL issue_extra: got 0x%0h, expected no issue", o_instr_out);
            end else chk("issue_data", o_instr_out, exp_data_q.pop_front());
            iss_tot++;
            iss_run++;
            if (first_vld < 0) first_vld = cyc;
            since_vld   = 0;
            stall_since = 0;
         end else begin
            if (o_instr_out !== '0) nop_viol++;
            if (o_done) begin
               done_cnt++;
               done_cyc    = cyc;
               drain_len   = since_vld;
               drain_stall = stall_since;
            end else begin
               since_vld++;
               if (i_ext_stall) stall_since++;
            end
         end
      end
   end

   task automatic launch(input logic [15:0] base, input logic [15:0] n);
      @(posedge clk);
      #1;
      for (int i = 0; i < int'(n); i++) begin
         exp_addr_q.push_back(16'(base + i));
         exp_data_q.push_back(mem_f(16'(base + i)));
      end
      i_base_addr = base;
      i_n_instr   = n;
      i_start     = 1'b1;
      n_cur = n; start_cyc = cyc; first_req = -1; first_vld = -1;
      pe_cnt = 0; iss_run = 0; since_vld = 0; stall_since = 0; req_seen = 0;
      s1 = 0; s2 = 0; max_if = 0; credit_viol = 0; nop_viol = 0; stall_viol = 0;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      chk("err_clear_on_start", o_err, 0);
   endtask

   task automatic run_prog(input logic [15:0] base, input logic [15:0] n);
      int d0;
      d0 = done_cnt;
      launch(base, n);
      for (int k = 0; k < 4000 && done_cnt == d0; k++) @(posedge clk);
      chk("done_pulse", done_cnt - d0, 1);
      #2;
      chk("busy_after_done", o_busy, 0);
      chk("done_one_cycle", o_done, 0);
      chk("pipe_en_cycles", pe_cnt, (n == 0) ? 0 : int'(n) + PIPE_DEPTH);
      chk("issued_all", exp_data_q.size(), 0);
      chk("fetched_all", exp_addr_q.size(), 0);
      if (n != 0) chk("drain_enabled_cycles", drain_len - drain_stall, PIPE_DEPTH);
      chk("nop_and_vld_rules", nop_viol, 0);
      chk("no_pop_in_stall", stall_viol, 0);
      chk("credit_rule", credit_viol, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {o_instr_req, o_pipe_en, o_instr_vld, o_busy, o_done, o_err}, 0);
      chk("rst_instr_out", o_instr_out, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_outputs", {o_instr_req, o_pipe_en, o_busy, o_done, o_err}, 0);

      // smoke
      run_prog(16'h0010, 16'd3);
      chk("first_req_latency", first_req - start_cyc, 1);
      chk("first_vld_latency", first_vld - start_cyc, 3);
      chk("smoke_drain_len", drain_len, PIPE_DEPTH);

      // empty program
      run_prog(16'h0055, 16'd0);
      chk("zero_done_latency", done_cyc - start_cyc, 1);
      chk("zero_no_req", req_seen, 0);

      // grant backpressure
      gnt_hold = 5;
      run_prog(16'h0300, 16'd5);

      // credit limit
      lat_base = 10;
      run_prog(16'h0400, 16'd8);
      chk("credit_peak", max_if, FIFO_DEPTH);
      lat_base = 1;

      // stall mid-run and in drain
      sched_stall = 1;
      run_prog(16'h0500, 16'd6);
      chk("stalled_drain_len", drain_len, PIPE_DEPTH + 2);
      sched_stall = 0;

      // randomized runs
      for (int r = 0; r < 5; r++) begin
         gnt_rand   = 1;
         lat_rand   = 1;
         stall_rand = 1;
         lat_base   = $urandom_range(1, 3);
         run_prog(16'($urandom), 16'($urandom_range(1, 12)));
      end
      gnt_rand = 0; lat_rand = 0; stall_rand = 0; lat_base = 1;

      // address wrap
      run_prog(16'hFFFE, 16'd4);

      // mid-run reset with stragglers
      begin
         int d0;
         d0 = done_cnt;
         lat_base = 10;
         launch(16'h0100, 16'd6);
         for (int k = 0; k < 200 && iss_run < 1; k++) @(posedge clk);
         #3;
         rst = 1'b1;
         #1;
         chk("async_rst_outputs",
             {o_instr_req, o_pipe_en, o_instr_vld, o_busy, o_done, o_err}, 0);
         chk("async_rst_addr", o_instr_addr, 0);
         chk("async_rst_instr_out", o_instr_out, 0);
         exp_data_q.delete();
         exp_addr_q.delete();
         gnt_tot = 0;
         iss_tot = 0;
         n_cur   = 0;
         @(posedge clk);
         #1;
         rst = 1'b0;
         for (int k = 0; k < 50 && pend_q.size() > 0; k++) @(posedge clk);
         @(posedge clk);
         #2;
         chk("straggler_sets_err", o_err, 1);
         chk("abort_no_done", done_cnt - d0, 0);
         chk("abort_idle", o_busy, 0);
         lat_base = 1;
      end
      run_prog(16'h0020, 16'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
